ntt_twiddle_gen: RTL
====================

Name: ntt_twiddle_gen

Overview:
- Parametrised streaming twiddle-factor generator for the NTT datapath.
- For a requested stage length N = 2^log_len it:
  - derives the stage root w = OMEGA^(2^(M-log_len)) mod P by repeated squaring;
  - streams w^0 .. w^(N-1) mod P over a valid/ready interface.
- Feeds the butterfly array directly and replaces the fixed 64x64 table with on-demand generation via a bit-serial modular multiplier.

Parameters:
- WIDTH, 64, coefficient/modulus width in bits; P < 2^(WIDTH-1) required.
- P, 4179340454199820289, prime modulus.
- OMEGA, 68630377364883, primitive 2^M-th root of unity mod P.
- M, 57, log2 of OMEGA's order.
- LOG_MAX_LEN, 6, largest accepted log_len; must satisfy LOG_MAX_LEN <= M.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, request pulse; sampled only when busy=0.
- log_len, in, clog2(LOG_MAX_LEN+1), stage length exponent; sampled with start.
- inv, in, 1, inverse-twiddle request; used only under the optional macro.
- busy, out, 1, high from accepted start until the final handshake.
- err, out, 1, one-cycle pulse on a rejected start.
- out_valid, out, 1, factor present.
- out_ready, in, 1, consumer accepts.
- out_data, out, WIDTH, current factor.
- out_idx, out, LOG_MAX_LEN, exponent index k of out_data.
- out_last, out, 1, high with the final factor (k = N-1).

Behaviour:
- Reset: all outputs 0; state IDLE; internal registers cleared.
- rst asserted mid-operation aborts immediately. No partial output follows the release of reset.
- Modmul: interleaved shift-add, MSB first, one multiplier bit per cycle.
  - Each cycle: acc = 2*acc mod P, then acc = acc + a mod P if the bit is set.
  - Each reduction is a single conditional subtract on a WIDTH+1-bit intermediate.
  - Exactly WIDTH cycles per product. One shared multiplier instance.
- FSM states: IDLE, SQUARE, EMIT, STEP.
- IDLE:
  - On start with 1 <= log_len <= LOG_MAX_LEN: latch L=log_len, r=OMEGA, cnt=M-L, busy=1.
  - If cnt=0, go to EMIT with w=OMEGA; otherwise go to SQUARE.
  - On start with log_len=0 or log_len>LOG_MAX_LEN: err=1 for one cycle; stay in IDLE.
- SQUARE: r = r*r mod P; cnt decrements per product. At cnt=0, set w=r, cur=1, k=0, go to EMIT.
- First out_valid rises (M-L)*WIDTH+1 cycles after the accepting edge.
- EMIT: out_valid=1, out_data=cur, out_idx=k, out_last=(k==N-1).
  - Outputs hold stable while out_ready=0.
  - On handshake with last: out_valid=0, busy=0, go to IDLE.
  - On handshake otherwise: go to STEP.
- STEP: cur = cur*w mod P; k++. Return to EMIT after WIDTH cycles, so throughput is 1 factor per WIDTH+1 cycles at full ready.
- start while busy=1: ignored; no err.
- Back-to-back: start may be asserted in the same cycle busy falls. It is sampled on the next cycle, when IDLE.
- k wraps never: N-1 < 2^LOG_MAX_LEN by construction.

Optional Feature:
- Macro TWIDDLE_INV_EN.
- Defined, inv=1 at start:
  - After SQUARE, an extra INVERT state computes w^-1 = w^(2^L-1) = product over i=0..L-1 of w^(2^i).
  - This takes 2*(L-1) products: (L-1) squarings interleaved with (L-1) accumulates.
  - EMIT/STEP then use w^-1, giving the sequence w^0, w^-1, .. w^-(N-1). out_idx still counts 0..N-1.
  - First valid is delayed by an additional 2*(L-1)*WIDTH cycles.
- Defined, inv=0: identical to the macro-absent behaviour.
- Undefined: inv is ignored; no INVERT state is synthesised.

Test Plan:
- Config for all scenarios: WIDTH=8, P=17, OMEGA=3, M=4, LOG_MAX_LEN=4.
- Forward stream: out_ready=1, start log_len=2.
  - First out_valid 17 cycles after accept.
  - Output 1,13,16,4; out_last only on 4.
  - busy falls after the last handshake.
- Full length: log_len=4, no squaring. Output 1,3,9,10,13,5,15,11,16,14,8,7,4,12,2,6 with idx 0..15.
- Backpressure: log_len=2; hold out_ready=0 for 5 cycles on idx 1. out_data stays 13 and out_valid stays 1; the sequence is unchanged.
- Errors:
  - start log_len=0: err pulses once, busy=0, no valid.
  - start log_len=5: same response.
  - Second start while busy: ignored, no err.
- Reset: assert rst during SQUARE and again during EMIT. All outputs go to 0 immediately; a new start with log_len=2 then produces 1,13,16,4 correctly.
- With TWIDDLE_INV_EN defined: inv=1, log_len=2 outputs 1,4,16,13; log_len=4 outputs 1,6,2,12,4,7,8,14,16,11,15,5,13,10,9,3.

Source files
------------

// File: rtl/ntt_twiddle_gen.sv
// Streaming NTT twiddle generator: stage root w = OMEGA^(2^(M-log_len)) by repeated squaring, then w^0..w^(N-1) mod P.
// Latency: first out_valid (M-log_len)*WIDTH+1 cycles after the accepting edge, then one factor per WIDTH+1 cycles.
// Backpressure: out_valid/out_data/out_idx/out_last hold while out_ready=0; no factor is skipped or repeated.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, log_len    request pulse and stage exponent (N = 2^log_len); sampled only while idle
//   inv               inverse-twiddle request, honoured only when TWIDDLE_INV_EN is defined
//   busy, err         busy from accepted start to final handshake; err pulses on a rejected start
//   out_valid/ready   factor handshake; out_data = w^k, out_idx = k, out_last marks k = N-1
//
// Optional feature macro: TWIDDLE_INV_EN adds an INVERT state producing w^-1 = w^(2^L-1),
// so a request with inv=1 streams w^0, w^-1, .. w^-(N-1).
module ntt_twiddle_gen #(
  parameter int unsigned      WIDTH       = 64,
  parameter logic [WIDTH-1:0] P           = WIDTH'(64'd4179340454199820289),
  parameter logic [WIDTH-1:0] OMEGA       = WIDTH'(64'd68630377364883),
  parameter int unsigned      M           = 57,
  parameter int unsigned      LOG_MAX_LEN = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [$clog2(LOG_MAX_LEN+1)-1:0] log_len,
  input  logic                             inv,
  output logic                             busy,
  output logic                             err,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WIDTH-1:0]                 out_data,
  output logic [LOG_MAX_LEN-1:0]           out_idx,
  output logic                             out_last
);

  localparam int unsigned LW = $clog2(LOG_MAX_LEN + 1);
  localparam int unsigned CW = $clog2(M + 1);
  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned KW = LOG_MAX_LEN;
  localparam int unsigned NW = LOG_MAX_LEN + 1;
  localparam logic [WIDTH:0] PX = {1'b0, P};

`ifdef TWIDDLE_INV_EN
  typedef enum logic [2:0] {IDLE, SQUARE, EMIT, STEP, INVERT} state_t;
`else
  typedef enum logic [1:0] {IDLE, SQUARE, EMIT, STEP} state_t;
`endif

  state_t           state, state_n;
  logic [WIDTH-1:0] r, r_n;          // running square during root derivation
  logic [WIDTH-1:0] w, w_n;          // stage root (or its inverse) used by STEP
  logic [WIDTH-1:0] cur, cur_n;      // current factor w^k
  logic [KW-1:0]    k, k_n;
  logic [CW-1:0]    cnt, cnt_n;      // products left in SQUARE / INVERT
  logic [LW-1:0]    len_q, len_n;
  logic             err_q, err_n;

  // Shared bit-serial multiplier: acc accumulates mul_a * mul_b MSB first.
  logic [WIDTH-1:0] acc, acc_n;
  logic [WIDTH-1:0] mul_a, ma_n;
  logic [WIDTH-1:0] mul_b, mb_n;
  logic [BW-1:0]    bit_cnt, bc_n;
  logic             mul_run, mul_done;
  logic [WIDTH:0]   dbl, sum;
  logic [WIDTH-1:0] dbl_m, mul_res;

  // Root hand-off into EMIT (or INVERT) shared by the IDLE and SQUARE exits.
  logic             root_done;
  logic [WIDTH-1:0] root_val;

  logic [NW-1:0]    n_len;
  logic [KW-1:0]    last_idx;

`ifdef TWIDDLE_INV_EN
  logic             inv_q, inv_n;
  logic             ph, ph_n;        // 0: square r, 1: fold r into w
  logic             root_inv;
  logic [LW-1:0]    root_len;
`else
  logic             unused_inv;
  assign unused_inv = inv;
`endif

  // One multiplier step. P < 2^(WIDTH-1) keeps both 2*acc and acc+a inside WIDTH+1 bits,
  // so a single conditional subtract restores each partial result to [0, P).
  always_comb begin
    dbl     = {acc, 1'b0};
    dbl_m   = (dbl >= PX) ? WIDTH'(dbl - PX) : dbl[WIDTH-1:0];
    sum     = {1'b0, dbl_m} + {1'b0, mul_a};
    mul_res = dbl_m;
    if (mul_b[WIDTH-1]) begin
      mul_res = (sum >= PX) ? WIDTH'(sum - PX) : sum[WIDTH-1:0];
    end
  end

  always_comb begin
    mul_run = (state == SQUARE) || (state == STEP);
`ifdef TWIDDLE_INV_EN
    if (state == INVERT) mul_run = 1'b1;
`endif
  end

  assign mul_done = mul_run && (bit_cnt == BW'(WIDTH - 1));

  // Index of the final factor, N-1 = 2^L - 1.
  always_comb begin
    n_len    = NW'(1) << len_q;
    last_idx = KW'(n_len - NW'(1));
  end

  always_comb begin
    state_n   = state;
    r_n       = r;
    w_n       = w;
    cur_n     = cur;
    k_n       = k;
    cnt_n     = cnt;
    len_n     = len_q;
    err_n     = 1'b0;
    acc_n     = acc;
    ma_n      = mul_a;
    mb_n      = mul_b;
    bc_n      = bit_cnt;
    root_done = 1'b0;
    root_val  = '0;
`ifdef TWIDDLE_INV_EN
    inv_n     = inv_q;
    ph_n      = ph;
    root_inv  = 1'b0;
    root_len  = '0;
`endif

    if (mul_run) begin
      acc_n = mul_res;
      mb_n  = mul_b << 1;
      bc_n  = bit_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        if (start) begin
          if ((log_len == '0) || (log_len > LW'(LOG_MAX_LEN))) begin
            err_n = 1'b1;
          end else begin
            len_n = log_len;
            r_n   = OMEGA;
            cnt_n = CW'(M) - CW'(log_len);
`ifdef TWIDDLE_INV_EN
            inv_n = inv;
`endif
            if (CW'(log_len) == CW'(M)) begin
              root_done = 1'b1;
              root_val  = OMEGA;
`ifdef TWIDDLE_INV_EN
              root_inv  = inv;
              root_len  = log_len;
`endif
            end else begin
              state_n = SQUARE;
              acc_n   = '0;
              ma_n    = OMEGA;
              mb_n    = OMEGA;
              bc_n    = '0;
            end
          end
        end
      end

      SQUARE: begin
        if (mul_done) begin
          r_n   = mul_res;
          cnt_n = cnt - 1'b1;
          if (cnt == CW'(1)) begin
            root_done = 1'b1;
            root_val  = mul_res;
`ifdef TWIDDLE_INV_EN
            root_inv  = inv_q;
            root_len  = len_q;
`endif
          end else begin
            acc_n = '0;
            ma_n  = mul_res;
            mb_n  = mul_res;
            bc_n  = '0;
          end
        end
      end

      EMIT: begin
        if (out_ready) begin
          if (k == last_idx) begin
            state_n = IDLE;
          end else begin
            state_n = STEP;
            acc_n   = '0;
            ma_n    = cur;
            mb_n    = w;
            bc_n    = '0;
          end
        end
      end

      STEP: begin
        if (mul_done) begin
          cur_n   = mul_res;
          k_n     = k + 1'b1;
          state_n = EMIT;
        end
      end

`ifdef TWIDDLE_INV_EN
      // w has order 2^L, so w^-1 = w^(2^L-1) = prod_{i<L} w^(2^i):
      // r walks the squares while w accumulates them.
      INVERT: begin
        if (mul_done) begin
          acc_n = '0;
          bc_n  = '0;
          if (!ph) begin
            r_n  = mul_res;
            ma_n = w;
            mb_n = mul_res;
            ph_n = 1'b1;
          end else begin
            w_n = mul_res;
            if (cnt == CW'(1)) begin
              state_n = EMIT;
              cur_n   = WIDTH'(1);
              k_n     = '0;
            end else begin
              cnt_n = cnt - 1'b1;
              ma_n  = r;
              mb_n  = r;
              ph_n  = 1'b0;
            end
          end
        end
      end
`endif

      default: state_n = IDLE;
    endcase

    if (root_done) begin
      w_n = root_val;
`ifdef TWIDDLE_INV_EN
      if (root_inv && (root_len > LW'(1))) begin
        state_n = INVERT;
        r_n     = root_val;
        cnt_n   = CW'(root_len) - CW'(1);
        ph_n    = 1'b0;
        acc_n   = '0;
        ma_n    = root_val;
        mb_n    = root_val;
        bc_n    = '0;
      end else
`endif
      begin
        // L = 1 needs no inversion: a root of order 2 is its own inverse.
        state_n = EMIT;
        cur_n   = WIDTH'(1);
        k_n     = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      r       <= '0;
      w       <= '0;
      cur     <= '0;
      k       <= '0;
      cnt     <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      acc     <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      bit_cnt <= '0;
`ifdef TWIDDLE_INV_EN
      inv_q   <= 1'b0;
      ph      <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      r       <= r_n;
      w       <= w_n;
      cur     <= cur_n;
      k       <= k_n;
      cnt     <= cnt_n;
      len_q   <= len_n;
      err_q   <= err_n;
      acc     <= acc_n;
      mul_a   <= ma_n;
      mul_b   <= mb_n;
      bit_cnt <= bc_n;
`ifdef TWIDDLE_INV_EN
      inv_q   <= inv_n;
      ph      <= ph_n;
`endif
    end
  end

  assign busy      = (state != IDLE);
  assign err       = err_q;
  assign out_valid = (state == EMIT);
  assign out_data  = out_valid ? cur : '0;
  assign out_idx   = out_valid ? k : '0;
  assign out_last  = out_valid && (k == last_idx);

endmodule
